// File: rtl/ddr_rd_capture_pkg.sv
// Shared types and constants for the DDR read-capture block.
// Holds the capture FSM state encoding and the MIG-style command codes.
package ddr_rd_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [2:0] WR_CMD = 3'b000;
  localparam logic [2:0] RD_CMD = 3'b001;

endpackage

// File: rtl/ddr_rd_capture_if.sv
// Bus bundle between the DDR read path, the controlling logic and the sample consumer.
// The slave modport is the capture block; the master modport is whatever drives it.
interface ddr_rd_capture_if #(
  parameter int APP_DATA_WIDTH   = 64,
  parameter int N                = 64,
  parameter int DDR_TS_MAX_WIDTH = 10,
  parameter int FIFO_DEPTH       = 16
);

  logic                            init_calib_complete;
  logic                            start;
  logic [DDR_TS_MAX_WIDTH:0]       max;
  logic [APP_DATA_WIDTH-1:0]       app_rd_data;
  logic                            app_rd_data_valid;
  logic                            app_rd_data_end;
  logic [N-1:0]                    out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;
  logic                            busy;
  logic                            done;
  logic                            overflow;
  logic [$clog2(FIFO_DEPTH):0]     fill;

  modport master (
    output init_calib_complete, start, max, app_rd_data, app_rd_data_valid,
           app_rd_data_end, out_ready,
    input  out_data, out_valid, out_last, busy, done, overflow, fill
  );

  modport slave (
    input  init_calib_complete, start, max, app_rd_data, app_rd_data_valid,
           app_rd_data_end, out_ready,
    output out_data, out_valid, out_last, busy, done, overflow, fill
  );

endinterface

// File: rtl/ddr_rd_capture_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: the head entry is always visible on o_rdata.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo_fwft #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_fill;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_full    = (r_fill == FULL_CNT);
  assign o_empty   = (r_fill == '0);
  assign o_fill    = r_fill;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage is deliberately left unreset; the head is masked by o_empty downstream.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_fill <= r_fill + (AW+1)'(1);
        2'b01:   r_fill <= r_fill - (AW+1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule

// File: rtl/ddr_rd_capture.sv
// Captures a run of DDR read beats into a FWFT FIFO and hands them to a consumer,
// tagging the final beat of the run and flagging beats lost to a full FIFO.
module ddr_rd_capture
  import ddr_rd_capture_pkg::*;
#(
  parameter int APP_DATA_WIDTH   = 64,
  parameter int N                = 64,
  parameter int DDR_TS_MAX_WIDTH = 10,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ddr_rd_capture_if.slave  bus
);

  localparam int MW = DDR_TS_MAX_WIDTH + 1;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  state_t        r_state;
  logic [MW-1:0] r_max;
  logic [MW-1:0] r_beat_cnt;
  logic          r_overflow;
  logic          r_done;

  logic          w_flush;
  logic          w_beat;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_last_beat;
  logic          w_drain_exit;
  logic          w_full;
  logic          w_empty;
  logic [FW-1:0] w_fill;
  logic [N:0]    w_head;

  assign w_flush     = !bus.init_calib_complete;
  assign w_beat      = (r_state == CAPTURE) && bus.app_rd_data_valid;
  assign w_pop       = !w_empty && bus.out_ready;
  assign w_push      = w_beat && (!w_full || w_pop);
  assign w_drop      = w_beat && w_full && !w_pop;
  assign w_last_beat = (r_beat_cnt == r_max - MW'(1));

  // With no pushes in DRAIN, popping the sole remaining entry covers a dropped last beat.
  assign w_drain_exit = (r_state == DRAIN) && w_pop &&
                        (w_head[N] || (w_fill == FW'(1)));

  sync_fifo_fwft #(
    .WIDTH (N + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata ({w_last_beat, bus.app_rd_data[N-1:0]}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_fill  (w_fill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_max      <= '0;
      r_beat_cnt <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else if (w_flush) begin
      r_state    <= IDLE;
      r_max      <= '0;
      r_beat_cnt <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_max      <= bus.max;
            r_beat_cnt <= '0;
            r_overflow <= 1'b0;
            if (bus.max == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          // Every valid beat advances the count, even one the FIFO has no room for.
          if (bus.app_rd_data_valid) begin
            r_beat_cnt <= r_beat_cnt + MW'(1);
            if (w_last_beat) begin
              r_state <= DRAIN;
            end
          end
          if (w_drop) begin
            r_overflow <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_drain_exit) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_data  = w_head[N-1:0];
  assign bus.out_valid = !w_empty;
  assign bus.out_last  = !w_empty && w_head[N];
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign bus.overflow  = r_overflow;
  assign bus.fill      = w_fill;

endmodule

// File: tb/tb_ddr_rd_capture.sv
// Directed bench for ddr_rd_capture: normal run, overflow, full-FIFO pass-through,
// zero-length start, calibration flush and asynchronous reset during DRAIN.
module tb_ddr_rd_capture;

  localparam int APP_DATA_WIDTH   = 64;
  localparam int N                = 64;
  localparam int DDR_TS_MAX_WIDTH = 10;
  localparam int FIFO_DEPTH       = 16;

  logic clk;
  logic rst_n;
  int   nVectors;
  int   nMiscompares;

  ddr_rd_capture_if #(
    .APP_DATA_WIDTH   (APP_DATA_WIDTH),
    .N                (N),
    .DDR_TS_MAX_WIDTH (DDR_TS_MAX_WIDTH),
    .FIFO_DEPTH       (FIFO_DEPTH)
  ) bus ();

  ddr_rd_capture #(
    .APP_DATA_WIDTH   (APP_DATA_WIDTH),
    .N                (N),
    .DDR_TS_MAX_WIDTH (DDR_TS_MAX_WIDTH),
    .FIFO_DEPTH       (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] beatData(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [10:0] mx, input logic vld,
                               input logic [63:0] dat, input logic rdy);
    bus.start             = st;
    bus.max               = mx;
    bus.app_rd_data_valid = vld;
    bus.app_rd_data       = dat;
    bus.out_ready         = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // A full accepted run starts by pulsing start for one cycle with the given length.
  task automatic startRun(input logic [10:0] mx, input logic rdy);
    applyStimulus(1'b1, mx, 1'b0, '0, rdy);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, '0, rdy);
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    rst_n                   = 1'b0;
    bus.init_calib_complete = 1'b1;
    bus.app_rd_data_end     = 1'b0;
    applyStimulus(1'b0, 11'd0, 1'b0, '0, 1'b0);
    #12;
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_last",  64'(bus.out_last),  64'd0);
    checkOutput("rst_busy",      64'(bus.busy),      64'd0);
    checkOutput("rst_done",      64'(bus.done),      64'd0);
    checkOutput("rst_overflow",  64'(bus.overflow),  64'd0);
    checkOutput("rst_fill",      64'(bus.fill),      64'd0);
    rst_n = 1'b1;
    tick();

    // Eight back-to-back beats streamed straight through to a ready consumer.
    startRun(11'd8, 1'b1);
    checkOutput("run8_busy", 64'(bus.busy), 64'd1);
    checkOutput("run8_empty", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 11'd0, 1'b1, beatData(i), 1'b1);
      tick();
      checkOutput($sformatf("run8_valid%0d", i), 64'(bus.out_valid), 64'd1);
      checkOutput($sformatf("run8_data%0d", i), bus.out_data, beatData(i));
      checkOutput($sformatf("run8_last%0d", i), 64'(bus.out_last), 64'(i == 7));
      checkOutput($sformatf("run8_fill%0d", i), 64'(bus.fill), 64'd1);
    end
    checkOutput("run8_drain_busy", 64'(bus.busy), 64'd1);
    checkOutput("run8_drain_done", 64'(bus.done), 64'd0);
    applyStimulus(1'b0, 11'd0, 1'b0, '0, 1'b1);
    tick();
    checkOutput("run8_done", 64'(bus.done), 64'd1);
    checkOutput("run8_idle", 64'(bus.busy), 64'd0);
    checkOutput("run8_valid_end", 64'(bus.out_valid), 64'd0);
    tick();
    checkOutput("run8_done_drop", 64'(bus.done), 64'd0);

    // Twenty beats into a sixteen-deep FIFO with the consumer stalled.
    startRun(11'd20, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 11'd0, 1'b1, beatData(100 + i), 1'b0);
      tick();
      checkOutput($sformatf("ovf_fill%0d", i), 64'(bus.fill), 64'((i < 16) ? i + 1 : 16));
      checkOutput($sformatf("ovf_flag%0d", i), 64'(bus.overflow), 64'(i >= 16));
    end
    applyStimulus(1'b0, 11'd0, 1'b0, '0, 1'b0);
    checkOutput("ovf_drain_busy", 64'(bus.busy), 64'd1);
    tick();
    checkOutput("ovf_idle_in_drain", 64'(bus.busy), 64'd1);
    checkOutput("ovf_fill_held", 64'(bus.fill), 64'd16);
    applyStimulus(1'b0, 11'd0, 1'b0, '0, 1'b1);
    for (int j = 0; j < 16; j++) begin
      checkOutput($sformatf("ovf_pop_data%0d", j), bus.out_data, beatData(100 + j));
      checkOutput($sformatf("ovf_pop_last%0d", j), 64'(bus.out_last), 64'd0);
      tick();
    end
    checkOutput("ovf_done", 64'(bus.done), 64'd1);
    checkOutput("ovf_idle", 64'(bus.busy), 64'd0);
    checkOutput("ovf_fill_empty", 64'(bus.fill), 64'd0);
    checkOutput("ovf_sticky", 64'(bus.overflow), 64'd1);
    tick();

    // A full FIFO accepts a beat when the consumer pops on the same edge.
    startRun(11'd20, 1'b0);
    checkOutput("full_ovf_cleared", 64'(bus.overflow), 64'd0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 11'd0, 1'b1, beatData(200 + i), 1'b0);
      tick();
    end
    checkOutput("full_fill16", 64'(bus.fill), 64'd16);
    for (int i = 16; i < 20; i++) begin
      applyStimulus(1'b0, 11'd0, 1'b1, beatData(200 + i), 1'b1);
      tick();
      checkOutput($sformatf("full_pass_fill%0d", i), 64'(bus.fill), 64'd16);
      checkOutput($sformatf("full_pass_ovf%0d", i), 64'(bus.overflow), 64'd0);
    end
    applyStimulus(1'b0, 11'd0, 1'b0, '0, 1'b1);
    for (int j = 0; j < 16; j++) begin
      checkOutput($sformatf("full_pop_data%0d", j), bus.out_data, beatData(204 + j));
      checkOutput($sformatf("full_pop_last%0d", j), 64'(bus.out_last), 64'(j == 15));
      tick();
    end
    checkOutput("full_done", 64'(bus.done), 64'd1);
    checkOutput("full_idle", 64'(bus.busy), 64'd0);
    tick();

    // Zero-length run only produces a done pulse.
    applyStimulus(1'b1, 11'd0, 1'b0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, 11'd0, 1'b0, '0, 1'b0);
    checkOutput("zero_busy", 64'(bus.busy), 64'd0);
    checkOutput("zero_done", 64'(bus.done), 64'd1);
    tick();
    checkOutput("zero_done_drop", 64'(bus.done), 64'd0);
    checkOutput("zero_busy_after", 64'(bus.busy), 64'd0);

    // Calibration loss mid-capture flushes everything without a done pulse.
    startRun(11'd8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 11'd0, 1'b1, beatData(300 + i), 1'b0);
      tick();
    end
    checkOutput("flush_fill5", 64'(bus.fill), 64'd5);
    applyStimulus(1'b0, 11'd0, 1'b0, '0, 1'b0);
    bus.init_calib_complete = 1'b0;
    tick();
    checkOutput("flush_fill", 64'(bus.fill), 64'd0);
    checkOutput("flush_busy", 64'(bus.busy), 64'd0);
    checkOutput("flush_done", 64'(bus.done), 64'd0);
    checkOutput("flush_valid", 64'(bus.out_valid), 64'd0);
    bus.init_calib_complete = 1'b1;
    tick();
    startRun(11'd2, 1'b1);
    applyStimulus(1'b0, 11'd0, 1'b1, beatData(400), 1'b1);
    tick();
    checkOutput("rerun_data0", bus.out_data, beatData(400));
    applyStimulus(1'b0, 11'd0, 1'b1, beatData(401), 1'b1);
    tick();
    checkOutput("rerun_data1", bus.out_data, beatData(401));
    checkOutput("rerun_last", 64'(bus.out_last), 64'd1);
    applyStimulus(1'b0, 11'd0, 1'b0, '0, 1'b1);
    tick();
    checkOutput("rerun_done", 64'(bus.done), 64'd1);
    tick();

    // Asynchronous reset between edges while draining.
    startRun(11'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 11'd0, 1'b1, beatData(500 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 11'd0, 1'b0, '0, 1'b0);
    checkOutput("areset_pre_fill", 64'(bus.fill), 64'd4);
    checkOutput("areset_pre_busy", 64'(bus.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("areset_last",  64'(bus.out_last),  64'd0);
    checkOutput("areset_busy",  64'(bus.busy),      64'd0);
    checkOutput("areset_done",  64'(bus.done),      64'd0);
    checkOutput("areset_ovf",   64'(bus.overflow),  64'd0);
    checkOutput("areset_fill",  64'(bus.fill),      64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("areset_no_done", 64'(bus.done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/ddr_rd_capture.md
DDR_RD_CAPTURE -- requirements
Module: ddr_rd_capture

Interface
REQ-001 Param APP_DATA_WIDTH, 64, width of the DDR read data bus.
REQ-002 Param N, 64, width of the output sample (N <= APP_DATA_WIDTH).
REQ-003 Param DDR_TS_MAX_WIDTH, 10, width of the beat counters; the max input is DDR_TS_MAX_WIDTH+1 bits.
REQ-004 Param FIFO_DEPTH, 16, number of FIFO entries (power of 2, >= 2).
REQ-005 Port clk  in  1  single clock; all logic is rising-edge.
REQ-006 Port rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port init_calib_complete  in  1  DDR calibration done; low forces a synchronous flush.
REQ-008 Port start  in  1  one-cycle pulse that arms a capture run.
REQ-009 Port max  in  DDR_TS_MAX_WIDTH+1  beats expected in the run; sampled on start.
REQ-010 Port app_rd_data  in  APP_DATA_WIDTH  DDR read beat.
REQ-011 Port app_rd_data_valid  in  1  beat qualifier; there is no backpressure to DDR.
REQ-012 Port app_rd_data_end  in  1  end-of-burst marker; ignored (BL8, one beat per command).
REQ-013 Port out_data  out  N  app_rd_data[N-1:0] of the FIFO head.
REQ-014 Port out_valid  out  1  FIFO not empty.
REQ-015 Port out_ready  in  1  the consumer accepts when out_valid & out_ready.
REQ-016 Port out_last  out  1  the head entry is beat number max of the run.
REQ-017 Port busy  out  1  state != IDLE.
REQ-018 Port done  out  1  one-cycle pulse at the end of a run.
REQ-019 Port overflow  out  1  sticky; a beat arrived while the FIFO was full.
REQ-020 Port fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-021 FSM states:
- IDLE -> CAPTURE on start with max != 0.
- CAPTURE -> DRAIN when the beat counter reaches max.
- DRAIN -> IDLE when the beat flagged last is popped.
REQ-022 start with max == 0 in IDLE: no state change; done pulses on the next cycle.
REQ-023 start while busy is ignored.
REQ-024 On the start edge: max is latched into max_r and the beat counter is cleared.
REQ-025 In CAPTURE, each app_rd_data_valid increments the beat counter whether or not the beat is stored.
REQ-026 Storing a beat: the store happens on the same edge; the data appears on out_data/out_valid the following cycle (first-word fall-through).
REQ-027 Beats arriving while in IDLE or DRAIN are discarded and do not set overflow.
REQ-028 Beat when fill == FIFO_DEPTH and no pop in the same cycle: the beat is dropped and overflow is set.
REQ-029 Push and pop in the same cycle while full: both occur and fill is unchanged.
REQ-030 Push and pop in the same cycle while empty is impossible, because out_valid is 0.
REQ-031 Each FIFO entry stores an extra last bit, set on the beat whose counter value equals max_r - 1 before the increment.
REQ-032 If the last beat was dropped (overflow): DRAIN exits to IDLE when the FIFO becomes empty.
REQ-033 done pulses for one cycle on the DRAIN -> IDLE transition.
REQ-034 overflow clears only on the next accepted start or on reset/flush.
REQ-035 Pointers wrap modulo FIFO_DEPTH; fill counts from 0 to FIFO_DEPTH inclusive.
REQ-036 init_calib_complete low: synchronous flush to IDLE; FIFO emptied; counters, max_r and overflow cleared; done not pulsed.

Reset
REQ-037 rst_n low asynchronously sets the state to IDLE and clears the pointers, fill, counters, max_r and overflow.
REQ-038 Output values under reset: out_valid=0, out_last=0, busy=0, done=0, overflow=0, fill=0.
REQ-039 FIFO storage is not reset; out_data is don't-care while out_valid is 0.
REQ-040 Reset asserted mid-run aborts the run with no done pulse.

Structure
REQ-041 A shared package holds the FSM state enum (IDLE, CAPTURE, DRAIN) and the RD_CMD/WR_CMD command constants.
REQ-042 One sub-module, sync_fifo_fwft, is parameterised by width (N+1) and depth, and provides fill, full and empty.

Verification
REQ-043 start, max=8; 8 valid beats back-to-back; out_ready=1 -> 8 outputs in order, out_last on the 8th, done 1 cycle after the last pop.
REQ-044 max=20, FIFO_DEPTH=16, out_ready=0 during capture -> fill saturates at 16, 4 beats dropped, overflow=1; after releasing out_ready: 16 pops, done, and out_last never seen.
REQ-045 Full FIFO with out_ready=1 and a valid beat in the same cycle -> fill stays 16 and no overflow.
REQ-046 start with max=0 -> busy stays 0 and done pulses once.
REQ-047 Drop init_calib_complete mid-CAPTURE (fill=5) -> next cycle: fill=0, busy=0, no done; a new start runs normally.
REQ-048 rst_n asserted asynchronously mid-edge during DRAIN -> outputs immediately take their reset values.
